// File: rtl/sprite_draw_arbiter.sv
// Round-robin arbiter sharing one 5x5 sprite drawer between several owners.
// Latches the winner's operands, pulses go, waits for done or timeout, acks.
module sprite_draw_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 255
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [N-1:0]    req,
    input  logic [8*N-1:0]  x_in,
    input  logic [7*N-1:0]  y_in,
    input  logic [25*N-1:0] shape_in,
    input  logic [3*N-1:0]  colour_in,
    input  logic            done,
    output logic            go,
    output logic [7:0]      x_out,
    output logic [6:0]      y_out,
    output logic [24:0]     shape_out,
    output logic [2:0]      colour_out,
    output logic [N-1:0]    ack,
    output logic            err,
    output logic            busy,
    output logic [2:0]      grant_id
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        ACK
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [2:0]    ptr;
    logic [2:0]    sel_id;
    logic          sel_found;
    logic [CW-1:0] cnt;
    logic          abort;
    logic          expire;

    assign expire = (cnt == CNT_LAST);

    // Search upward from ptr, wrapping modulo N; first pending owner wins.
    always_comb begin : pick
        logic [3:0] pos;
        sel_found = 1'b0;
        sel_id    = 3'd0;
        pos       = 4'd0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + 4'(k);
            if (pos >= 4'(N)) pos = pos - 4'(N);
            for (int i = 0; i < N; i++) begin
                if (!sel_found && req[i] && pos[2:0] == 3'(i)) begin
                    sel_found = 1'b1;
                    sel_id    = 3'(i);
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:      if (sel_found) state_next = ISSUE;
            ISSUE:     state_next = WAIT_DONE;
            WAIT_DONE: if (done || expire) state_next = ACK;
            ACK:       state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            ptr        <= 3'd0;
            cnt        <= '0;
            abort      <= 1'b0;
            grant_id   <= 3'd0;
            x_out      <= 8'd0;
            y_out      <= 7'd0;
            shape_out  <= 25'd0;
            colour_out <= 3'd0;
        end else begin
            state <= state_next;
            unique case (state)
                IDLE: begin
                    if (sel_found) begin
                        grant_id <= sel_id;
                        for (int i = 0; i < N; i++) begin
                            if (sel_id == 3'(i)) begin
                                x_out      <= x_in[8*i +: 8];
                                y_out      <= y_in[7*i +: 7];
                                shape_out  <= shape_in[25*i +: 25];
                                colour_out <= colour_in[3*i +: 3];
                            end
                        end
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    abort <= 1'b0;
                end
                WAIT_DONE: begin
                    // done on the expiry cycle still counts as success
                    if (!done) begin
                        if (expire) abort <= 1'b1;
                        else cnt <= cnt + 1'b1;
                    end
                end
                ACK: begin
                    ptr <= (grant_id == 3'(N - 1)) ? 3'd0 : grant_id + 3'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ack = '0;
        if (state == ACK) begin
            for (int i = 0; i < N; i++) ack[i] = (grant_id == 3'(i));
        end
    end

    assign go   = (state == ISSUE);
    assign err  = (state == ACK) && abort;
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_sprite_draw_arbiter.sv
// Directed and randomized checks of sprite_draw_arbiter against a
// transaction-level round-robin model with explicit cycle expectations.
module tb_sprite_draw_arbiter;

    localparam int N = 4;
    localparam int TO = 64;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic [8*N-1:0]  x_in = '0;
    logic [7*N-1:0]  y_in = '0;
    logic [25*N-1:0] shape_in = '0;
    logic [3*N-1:0]  colour_in = '0;
    logic          done = 1'b0;
    logic          go;
    logic [7:0]    x_out;
    logic [6:0]    y_out;
    logic [24:0]   shape_out;
    logic [2:0]    colour_out;
    logic [N-1:0]  ack;
    logic          err;
    logic          busy;
    logic [2:0]    grant_id;

    int total = 0;
    int bad = 0;
    int m_ptr = 0;

    sprite_draw_arbiter #(.N(N), .TIMEOUT(TO)) dut (
        .clock(clock), .reset_n(reset_n), .req(req),
        .x_in(x_in), .y_in(y_in), .shape_in(shape_in),
        .colour_in(colour_in), .done(done), .go(go),
        .x_out(x_out), .y_out(y_out), .shape_out(shape_out),
        .colour_out(colour_out), .ack(ack), .err(err),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first pending owner at or after ptr, wrapping.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_go"}, 32'(go), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_ack"}, 32'(ack), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_x"}, 32'(x_out), 0);
        chk({tag, "_y"}, 32'(y_out), 0);
        chk({tag, "_shape"}, 32'(shape_out), 0);
        chk({tag, "_colour"}, 32'(colour_out), 0);
        chk({tag, "_gid"}, 32'(grant_id), 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req = '0;
        done = 1'b0;
        repeat (2) @(negedge clock);
        check_zero("reset");
        reset_n = 1'b1;
        m_ptr = 0;
        @(negedge clock);
    endtask

    // Call at a negedge with DUT idle and req set; returns at next idle negedge.
    // lat = cycles from go to done; 0 means done never comes.
    task automatic serve(input int lat, input bit scr, input bit spur,
                         input bit drop);
        int id;
        int ack_at;
        logic [7:0] ex;
        logic [6:0] ey;
        logic [24:0] es;
        logic [2:0] ec;
        id = pick(req, m_ptr);
        ex = x_in[8*id +: 8];
        ey = y_in[7*id +: 7];
        es = shape_in[25*id +: 25];
        ec = colour_in[3*id +: 3];
        @(negedge clock);
        chk("issue_go", 32'(go), 1);
        chk("issue_busy", 32'(busy), 1);
        chk("issue_gid", 32'(grant_id), 32'(id));
        chk("issue_x", 32'(x_out), 32'(ex));
        chk("issue_y", 32'(y_out), 32'(ey));
        chk("issue_shape", 32'(shape_out), 32'(es));
        chk("issue_colour", 32'(colour_out), 32'(ec));
        chk("issue_ack", 32'(ack), 0);
        if (spur) done = 1'b1;
        if (scr) begin
            x_in[8*id +: 8] = ~ex;
            shape_in[25*id +: 25] = ~es;
        end
        if (drop) req[id] = 1'b0;
        ack_at = (lat > 0) ? lat + 1 : TO + 1;
        for (int k = 1; k < ack_at; k++) begin
            @(negedge clock);
            done = (lat > 0 && k == lat);
            chk("wait_go", 32'(go), 0);
            chk("wait_ack", 32'(ack), 0);
            chk("wait_busy", 32'(busy), 1);
            chk("wait_x", 32'(x_out), 32'(ex));
            chk("wait_shape", 32'(shape_out), 32'(es));
        end
        @(negedge clock);
        done = 1'b0;
        chk("ack_onehot", 32'(ack), 32'(1) << id);
        chk("ack_err", 32'(err), (lat == 0) ? 1 : 0);
        chk("ack_busy", 32'(busy), 1);
        chk("ack_go", 32'(go), 0);
        chk("ack_gid", 32'(grant_id), 32'(id));
        chk("ack_y", 32'(y_out), 32'(ey));
        chk("ack_colour", 32'(colour_out), 32'(ec));
        m_ptr = (id + 1) % N;
        @(negedge clock);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_ack", 32'(ack), 0);
        chk("idle_err", 32'(err), 0);
    endtask

    // Start a grant, then pull reset in the middle of WAIT_DONE.
    task automatic mid_reset(input logic [N-1:0] r);
        int id;
        req = r;
        id = pick(req, m_ptr);
        @(negedge clock);
        chk("mr_go", 32'(go), 1);
        chk("mr_gid", 32'(grant_id), 32'(id));
        req = '0;
        repeat (4) @(negedge clock);
        chk("mr_busy", 32'(busy), 1);
        reset_n = 1'b0;
        #1;
        check_zero("midreset");
        m_ptr = 0;
        @(negedge clock);
        chk("mr_noack", 32'(ack), 0);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        // reset state
        do_reset();

        // single requester, done 30 cycles after go
        x_in[7:0] = 8'd3;
        y_in[6:0] = 7'd7;
        colour_in[2:0] = 3'b110;
        shape_in[24:0] = 25'h1F0_A5C3;
        req = 4'b0001;
        serve(30, 0, 0, 1);

        // simultaneous requests
        do_reset();
        for (int i = 0; i < N; i++) begin
            x_in[8*i +: 8] = 8'(10 + i);
            y_in[7*i +: 7] = 7'(20 + i);
            shape_in[25*i +: 25] = 25'(32'h0123_4567 * (i + 1));
            colour_in[3*i +: 3] = 3'(i + 1);
        end
        req = 4'b0110;
        serve(4, 0, 0, 0);
        serve(4, 0, 0, 0);
        req = 4'b0011;
        serve(4, 0, 0, 0);
        serve(4, 0, 0, 0);
        req = '0;

        // persistent contention
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 6; i++) serve(25, 0, 0, 0);
        req = '0;

        // timeout, then a normal grant
        do_reset();
        req = 4'b0100;
        serve(0, 0, 0, 1);
        req = 4'b0001;
        serve(5, 0, 0, 1);

        // done exactly on the expiry cycle is a success
        req = 4'b0010;
        serve(TO, 0, 0, 1);

        // operand isolation and spurious done during ISSUE
        do_reset();
        req = 4'b0100;
        serve(10, 1, 1, 1);

        // reset mid-operation
        mid_reset(4'b0010);
        req = 4'b1000;
        serve(8, 0, 0, 1);
        req = 4'b0010;
        serve(3, 0, 0, 1);
        mid_reset(4'b0001);
        req = 4'b1010;
        serve(3, 0, 0, 0);
        req = '0;

        // randomized traffic
        for (int it = 0; it < 14; it++) begin
            int lat;
            req = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
                x_in[8*i +: 8] = 8'($urandom);
                y_in[7*i +: 7] = 7'($urandom);
                shape_in[25*i +: 25] = 25'($urandom);
                colour_in[3*i +: 3] = 3'($urandom);
            end
            lat = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 40));
            serve(lat, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
        end
        req = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
